mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative unsigned multiply/divide unit; consumes register-file read operands, writes results back.
//  Operands come from reg_file rd_data1/rd_data2; its wr_addr/wr_data/wr_en drive the reg_file write port.
//  Double-width result: two consecutive write-back cycles (dst, dst+1). Controller stalls on busy.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=2)
//  LENGTH  4  register count (>=2); localparam ADDR_WIDTH = $clog2(LENGTH)
// PORTS
//  clk      in   1           clock, rising edge
//  rst      in   1           synchronous reset, active-high
//  start    in   1           request; accepted only in IDLE
//  op       in   2           00 MULU, 01 DIVU, 1x illegal
//  opa      in   WIDTH       multiplicand / dividend (reg_file rd_data1)
//  opb      in   WIDTH       multiplier / divisor (reg_file rd_data2)
//  dst      in   ADDR_WIDTH  destination base register
//  busy     out  1           high in CALC, WB_LO, WB_HI
//  done     out  1           1-cycle pulse in WB_HI
//  err      out  1           1-cycle pulse after illegal op accepted
//  wr_en    out  1           reg_file write enable
//  wr_addr  out  ADDR_WIDTH  reg_file write address
//  wr_data  out  WIDTH       reg_file write data
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0, internal regs 0. Reset mid-operation aborts, no further writes.
//  - Outputs are Moore (decoded from registered state/regs), never combinational from inputs.
//  - IDLE: start=1 latches op, opa, opb, dst at the clock edge.
//      legal op -> CALC, counter=WIDTH-1; illegal op -> ERR.
//  - start while busy=1 (incl. WB_HI cycle) ignored, not queued. opa/opb/dst changes after accept ignored.
//  - ERR: err=1 one cycle, wr_en=0, busy=0 -> IDLE. A start in ERR cycle is ignored.
//  - CALC: exactly WIDTH cycles, one bit per cycle; counter decrements, leaves at counter==0.
//      MULU: shift-add, 2*WIDTH-bit product P = opa*opb (exact, no overflow).
//      DIVU: restoring division, Q = opa/opb, R = opa%opb.
//      Divide by zero: Q = all ones, R = opa. No err.
//  - WB_LO: wr_en=1, wr_addr=dst, wr_data = P[WIDTH-1:0] (MULU) or Q (DIVU).
//  - WB_HI: wr_en=1, wr_addr=(dst+1) mod LENGTH, wr_data = P[2*WIDTH-1:WIDTH] or R; done=1 -> IDLE.
//  - dst=LENGTH-1 wraps hi write to register 0. wr_addr/wr_data = 0 when wr_en=0.
//  - Timing, start accepted at edge E0:
//      busy from E0; CALC cycles 1..WIDTH; WB_LO cycle WIDTH+1; WB_HI cycle WIDTH+2.
//      Next start is accepted at the edge ending cycle WIDTH+3 (IDLE), i.e. 1 idle cycle minimum.
//  - Register file captures each write at the edge ending its WB cycle.
//      Reading dst in WB_HI returns the low result.
// TESTING (WIDTH=8, LENGTH=4, checks against a reg_file instance on the write port)
//  1. MULU opa=AA opb=BB dst=0 -> r0=2E, r1=7C.
//     wr_en high exactly cycles 9,10 after accept; done in cycle 10 only.
//  2. DIVU opa=DD opb=0C dst=2 -> r2=12, r3=05.
//     busy high 10 cycles, then low.
//  3. DIVU opa=CC opb=00 dst=3 -> r3=FF, r0=CC (wrap).
//     err stays 0.
//  4. start pulsed each cycle during busy with op=MULU, opa=FF -> ignored.
//     Only original result written; next accept only after return to IDLE.
//  5. op=10 start -> err pulse 1 cycle, no wr_en, busy stays 0, regs unchanged.
//     Then MULU FF*FF dst=1 -> r1=01, r2=FE.
//  6. rst asserted in CALC cycle 4 of a MULU -> next cycle all outputs 0, state IDLE.
//     No writes occur; a new op then completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit with two-cycle register-file write-back.
// Produces one result bit per CALC cycle: shift-add for MULU, restoring division for DIVU.
module mul_div_unit #(
    parameter  int WIDTH      = 8,
    parameter  int LENGTH     = 4,
    localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [WIDTH-1:0]      opa_i,
    input  logic [WIDTH-1:0]      opb_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [WIDTH-1:0]      wr_data_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_WB_LO = 3'd2,
        S_WB_HI = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  div_q, div_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      m_q, m_d;
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // hi holds the partial product / remainder, lo the multiplier / quotient bits.
    assign add_sum = {1'b0, hi_q} + {1'b0, m_q};
    assign shifted = {hi_q, lo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, m_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            div_q   <= 1'b0;
            dst_q   <= '0;
            cnt_q   <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    div_d = op_i[0];
                    dst_d = dst_i;
                    if (op_i[1]) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CW'(WIDTH - 1);
                        hi_d    = '0;
                        m_d     = op_i[0] ? opb_i : opa_i;
                        lo_d    = op_i[0] ? opa_i : opb_i;
                    end
                end
            end
            S_CALC: begin
                if (div_q) begin
                    // A zero divisor never goes negative, giving all-ones Q and R = dividend.
                    if (!trial[WIDTH]) begin
                        hi_d = trial[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = shifted[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else if (lo_q[0]) begin
                    {hi_d, lo_d} = {add_sum, lo_q[WIDTH-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_WB_LO;
                end
            end
            S_WB_LO: state_d = S_WB_HI;
            S_WB_HI: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state_q == S_CALC) || (state_q == S_WB_LO) || (state_q == S_WB_HI);
        done_o    = (state_q == S_WB_HI);
        err_o     = (state_q == S_ERR);
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        if (state_q == S_WB_LO) begin
            wr_en_o   = 1'b1;
            wr_addr_o = dst_q;
            wr_data_o = lo_q;
        end else if (state_q == S_WB_HI) begin
            wr_en_o   = 1'b1;
            wr_addr_o = (dst_q == ADDR_WIDTH'(LENGTH - 1)) ? '0 : dst_q + ADDR_WIDTH'(1);
            wr_data_o = hi_q;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: register-file model on the write port plus a write scoreboard.
module tb_mul_div_unit;

    localparam int W = 8;
    localparam int L = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] opa, opb;
    logic [1:0] dst;
    logic       busy, done, err, wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    mul_div_unit #(.WIDTH(W), .LENGTH(L)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .opa_i    (opa),
        .opb_i    (opb),
        .dst_i    (dst),
        .busy_o   (busy),
        .done_o   (done),
        .err_o    (err),
        .wr_en_o  (wr_en),
        .wr_addr_o(wr_addr),
        .wr_data_o(wr_data)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rf [L] = '{default: 8'h00};

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sbq[$];

    always @(posedge clk) if (wr_en === 1'b1) rf[wr_addr] <= wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            vectors++;
            assert (sbq.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", wr_addr, wr_data);
            end
            if (sbq.size() > 0) begin
                wr_t e;
                e = sbq.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] d, input bit junk);
        logic [15:0] p;
        logic [7:0]  elo, ehi;
        if (o == 2'b00) begin
            p   = 16'(a) * 16'(b);
            elo = p[7:0];
            ehi = p[15:8];
        end else if (b == 8'h00) begin
            elo = 8'hFF;
            ehi = a;
        end else begin
            elo = a / b;
            ehi = a % b;
        end
        sbq.push_back('{addr: d, data: elo});
        sbq.push_back('{addr: d + 2'd1, data: ehi});
        start = 1'b1; op = o; opa = a; opb = b; dst = d;
        step();
        for (int c = 1; c <= W + 2; c++) begin
            if (junk) begin
                start = 1'b1; op = 2'b00; opa = 8'hFF;
            end else begin
                start = 1'b0; opa = 8'($urandom);
            end
            opb = 8'($urandom);
            dst = 2'($urandom);
            check("busy", busy, 1);
            check("wr_en_cycle", wr_en, (c >= W + 1) ? 1 : 0);
            check("done_cycle", done, (c == W + 2) ? 1 : 0);
            check("err_quiet", err, 0);
            if (c <= W) begin
                check("wr_addr_zero", wr_addr, 0);
                check("wr_data_zero", wr_data, 0);
            end
            if (c == W + 2) check("rf_lo_in_wb_hi", rf[d], elo);
            step();
        end
        start = 1'b0;
        check("busy_after", busy, 0);
        check("wr_en_after", wr_en, 0);
        check("done_after", done, 0);
        check("rf_lo", rf[d], elo);
        check("rf_hi", rf[d + 2'd1], ehi);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; opa = 8'h00; opb = 8'h00; dst = 2'd0;
        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();
        check_idle_outputs("post_reset");

        // 1: MULU AA*BB = 7C2E
        run_op(2'b00, 8'hAA, 8'hBB, 2'd0, 1'b0);
        check("t1_r0", rf[0], 8'h2E);
        check("t1_r1", rf[1], 8'h7C);

        // 2: DIVU DD/0C = 12 r 05
        run_op(2'b01, 8'hDD, 8'h0C, 2'd2, 1'b0);
        check("t2_r2", rf[2], 8'h12);
        check("t2_r3", rf[3], 8'h05);

        // 3: divide by zero, hi write wraps to r0
        run_op(2'b01, 8'hCC, 8'h00, 2'd3, 1'b0);
        check("t3_r3", rf[3], 8'hFF);
        check("t3_r0", rf[0], 8'hCC);

        // 4: start hammered while busy is ignored
        run_op(2'b01, 8'h64, 8'h07, 2'd0, 1'b1);
        check("t4_r0", rf[0], 8'h0E);
        check("t4_r1", rf[1], 8'h02);

        // 5: illegal op, then a start during ERR is dropped
        start = 1'b1; op = 2'b10; opa = 8'h55; opb = 8'h66; dst = 2'd1;
        step();
        start = 1'b1; op = 2'b00;
        check("t5_err", err, 1);
        check("t5_busy", busy, 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_done", done, 0);
        step();
        start = 1'b0;
        check("t5_err_gone", err, 0);
        check("t5_start_in_err_ignored", busy, 0);
        step();
        check("t5_idle", busy, 0);
        check("t5_r0", rf[0], 8'h0E);
        check("t5_r1", rf[1], 8'h02);
        check("t5_r2", rf[2], 8'h12);
        check("t5_r3", rf[3], 8'hFF);
        run_op(2'b00, 8'hFF, 8'hFF, 2'd1, 1'b0);
        check("t5_mul_r1", rf[1], 8'h01);
        check("t5_mul_r2", rf[2], 8'hFE);

        // 6: reset in CALC cycle 4 aborts without writing
        start = 1'b1; op = 2'b00; opa = 8'h12; opb = 8'h34; dst = 2'd2;
        step();
        start = 1'b0;
        repeat (3) step();
        check("t6_busy_calc", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_outputs("t6_abort");
        for (int i = 0; i < 12; i++) begin
            check("t6_no_write", wr_en, 0);
            step();
        end
        check("t6_r2_kept", rf[2], 8'hFE);
        run_op(2'b00, 8'h0F, 8'h11, 2'd2, 1'b0);
        check("t6_r2", rf[2], 8'hFF);
        check("t6_r3", rf[3], 8'h00);

        step();
        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
